// File: rtl/search_peak_pkg.sv
// rtl/search_peak_pkg.sv - shared types and constants for the windowed peak tracker
package search_peak_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int DEF_WIN_LEN = 256;
  localparam int DEF_EN_HOLD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } pub_state_t;

endpackage

// File: rtl/search_peak_if.sv
// rtl/search_peak_if.sv - four-channel sample in / peak result out bundle
interface search_peak_if;
  import search_peak_pkg::*;

  logic [SAMPLE_W-1:0] din0, din1, din2, din3;
  logic                din0_valid, din1_valid, din2_valid, din3_valid;
  logic [SAMPLE_W-1:0] dat0_max, dat1_max, dat2_max, dat3_max;
  logic [SAMPLE_W-1:0] dat0_min, dat1_min, dat2_min, dat3_min;
  logic                dat0_max_en, dat1_max_en, dat2_max_en, dat3_max_en;
  logic                dat0_ovf, dat1_ovf, dat2_ovf, dat3_ovf;

  modport master (
    output din0, din1, din2, din3,
    output din0_valid, din1_valid, din2_valid, din3_valid,
    input  dat0_max, dat1_max, dat2_max, dat3_max,
    input  dat0_min, dat1_min, dat2_min, dat3_min,
    input  dat0_max_en, dat1_max_en, dat2_max_en, dat3_max_en,
    input  dat0_ovf, dat1_ovf, dat2_ovf, dat3_ovf
  );

  modport slave (
    input  din0, din1, din2, din3,
    input  din0_valid, din1_valid, din2_valid, din3_valid,
    output dat0_max, dat1_max, dat2_max, dat3_max,
    output dat0_min, dat1_min, dat2_min, dat3_min,
    output dat0_max_en, dat1_max_en, dat2_max_en, dat3_max_en,
    output dat0_ovf, dat1_ovf, dat2_ovf, dat3_ovf
  );

endinterface

// File: rtl/search_peak_window.sv
// rtl/search_peak_window.sv - one channel: window max/min accumulator, pending slot and publish FSM
module peak_window
  import search_peak_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int EN_HOLD = DEF_EN_HOLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                din_valid,
  output logic [SAMPLE_W-1:0] dat_max,
  output logic [SAMPLE_W-1:0] dat_min,
  output logic                max_en,
  output logic                ovf
);

  localparam int            CW        = $clog2(WIN_LEN);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIN_LEN - 1);
  localparam logic [7:0]    HOLD_LAST = 8'(EN_HOLD - 1);

  logic [CW-1:0]       cnt;
  logic [SAMPLE_W-1:0] run_max, run_min;
  logic [SAMPLE_W-1:0] nxt_max, nxt_min;
  logic                done;

  pub_state_t          state, state_nxt;
  logic [7:0]          hold_cnt;
  logic                pend_flag;
  logic [SAMPLE_W-1:0] pend_max, pend_min;
  logic                publish, capture;
  logic [SAMPLE_W-1:0] pub_max, pub_min;

  // First sample of a window reloads both extremes so nothing leaks across windows.
  always_comb begin
    nxt_max = run_max;
    nxt_min = run_min;
    if (cnt == '0) begin
      nxt_max = din;
      nxt_min = din;
    end else begin
      if (din > run_max) nxt_max = din;
      if (din < run_min) nxt_min = din;
    end
  end

  assign done = din_valid && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      run_max <= '0;
      run_min <= '0;
    end else if (din_valid) begin
      cnt     <= done ? '0 : cnt + 1'b1;
      run_max <= nxt_max;
      run_min <= nxt_min;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (done || pend_flag)     state_nxt = ST_HOLD;
      ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_GAP;
      ST_GAP:                             state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Pending always goes out before a same-cycle completion, which then takes the slot.
  always_comb begin
    max_en  = (state == ST_HOLD);
    publish = (state == ST_IDLE) && (done || pend_flag);
    capture = done && ((state != ST_IDLE) || pend_flag);
    pub_max = pend_flag ? pend_max : nxt_max;
    pub_min = pend_flag ? pend_min : nxt_min;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      dat_max   <= '0;
      dat_min   <= '0;
      pend_flag <= 1'b0;
      pend_max  <= '0;
      pend_min  <= '0;
      ovf       <= 1'b0;
    end else begin
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + 8'd1 : 8'd0;
      if (publish) begin
        dat_max <= pub_max;
        dat_min <= pub_min;
      end
      if (capture) begin
        pend_max  <= nxt_max;
        pend_min  <= nxt_min;
        pend_flag <= 1'b1;
        if (pend_flag && (state != ST_IDLE)) ovf <= 1'b1;
      end else if (publish) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/search_peak.sv
// rtl/search_peak.sv - four independent windowed peak trackers feeding the alarm stage
module search_peak
  import search_peak_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int EN_HOLD = DEF_EN_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  search_peak_if.slave  bus
);

  peak_window #(.WIN_LEN(WIN_LEN), .EN_HOLD(EN_HOLD)) u_ch0 (
    .clk(clk), .rst(rst),
    .din(bus.din0), .din_valid(bus.din0_valid),
    .dat_max(bus.dat0_max), .dat_min(bus.dat0_min),
    .max_en(bus.dat0_max_en), .ovf(bus.dat0_ovf)
  );

  peak_window #(.WIN_LEN(WIN_LEN), .EN_HOLD(EN_HOLD)) u_ch1 (
    .clk(clk), .rst(rst),
    .din(bus.din1), .din_valid(bus.din1_valid),
    .dat_max(bus.dat1_max), .dat_min(bus.dat1_min),
    .max_en(bus.dat1_max_en), .ovf(bus.dat1_ovf)
  );

  peak_window #(.WIN_LEN(WIN_LEN), .EN_HOLD(EN_HOLD)) u_ch2 (
    .clk(clk), .rst(rst),
    .din(bus.din2), .din_valid(bus.din2_valid),
    .dat_max(bus.dat2_max), .dat_min(bus.dat2_min),
    .max_en(bus.dat2_max_en), .ovf(bus.dat2_ovf)
  );

  peak_window #(.WIN_LEN(WIN_LEN), .EN_HOLD(EN_HOLD)) u_ch3 (
    .clk(clk), .rst(rst),
    .din(bus.din3), .din_valid(bus.din3_valid),
    .dat_max(bus.dat3_max), .dat_min(bus.dat3_min),
    .max_en(bus.dat3_max_en), .ovf(bus.dat3_ovf)
  );

endmodule

// File: tb/tb_search_peak.sv
// tb/tb_search_peak.sv - directed vector bench for search_peak
module tb_search_peak;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  search_peak_if a ();
  search_peak_if b ();

  search_peak #(.WIN_LEN(4), .EN_HOLD(4)) dut  (.clk(clk), .rst(rst), .bus(a));
  search_peak #(.WIN_LEN(2), .EN_HOLD(4)) dut2 (.clk(clk), .rst(rst), .bus(b));

  typedef struct {
    bit          do_reset;
    int          ch;
    logic [15:0] s [4];
    logic [15:0] emax;
    logic [15:0] emin;
  } vec_t;

  vec_t vecs [3];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(int ch, logic [15:0] d, logic v);
    case (ch)
      0: begin a.din0 = d; a.din0_valid = v; end
      1: begin a.din1 = d; a.din1_valid = v; end
      2: begin a.din2 = d; a.din2_valid = v; end
      default: begin a.din3 = d; a.din3_valid = v; end
    endcase
  endtask

  function automatic logic [15:0] get_max(int ch);
    case (ch)
      0: return a.dat0_max;
      1: return a.dat1_max;
      2: return a.dat2_max;
      default: return a.dat3_max;
    endcase
  endfunction

  function automatic logic [15:0] get_min(int ch);
    case (ch)
      0: return a.dat0_min;
      1: return a.dat1_min;
      2: return a.dat2_min;
      default: return a.dat3_min;
    endcase
  endfunction

  function automatic logic get_en(int ch);
    case (ch)
      0: return a.dat0_max_en;
      1: return a.dat1_max_en;
      2: return a.dat2_max_en;
      default: return a.dat3_max_en;
    endcase
  endfunction

  function automatic logic get_ovf(int ch);
    case (ch)
      0: return a.dat0_ovf;
      1: return a.dat1_ovf;
      2: return a.dat2_ovf;
      default: return a.dat3_ovf;
    endcase
  endfunction

  task automatic check_zero(string tag);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s_max%0d", tag, c), 32'(get_max(c)), 32'h0);
      check($sformatf("%s_min%0d", tag, c), 32'(get_min(c)), 32'h0);
      check($sformatf("%s_en%0d", tag, c), 32'(get_en(c)), 32'h0);
      check($sformatf("%s_ovf%0d", tag, c), 32'(get_ovf(c)), 32'h0);
    end
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic feed4(int ch, logic [15:0] s0, logic [15:0] s1, logic [15:0] s2, logic [15:0] s3);
    logic [15:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int j = 0; j < 4; j++) begin
      set_in(ch, s[j], 1'b1);
      @(posedge clk); #1;
    end
    set_in(ch, 16'h0, 1'b0);
  endtask

  initial begin
    int n;
    int rises;
    int run;
    logic prev;
    logic en;
    int rise_edge [3];
    logic [15:0] r_max [3];
    logic [15:0] r_min [3];

    vecs[0].do_reset = 1'b0; vecs[0].ch = 0;
    vecs[0].s = '{16'h1000, 16'h9000, 16'h0500, 16'h7000};
    vecs[0].emax = 16'h9000; vecs[0].emin = 16'h0500;
    vecs[1].do_reset = 1'b0; vecs[1].ch = 0;
    vecs[1].s = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
    vecs[1].emax = 16'h2000; vecs[1].emin = 16'h2000;
    vecs[2].do_reset = 1'b1; vecs[2].ch = 2;
    vecs[2].s = '{16'hFFFF, 16'h0000, 16'h8000, 16'h8000};
    vecs[2].emax = 16'hFFFF; vecs[2].emin = 16'h0000;

    for (int c = 0; c < 4; c++) set_in(c, 16'h0, 1'b0);
    b.din0 = '0; b.din1 = '0; b.din2 = '0; b.din3 = '0;
    b.din0_valid = 0; b.din1_valid = 0; b.din2_valid = 0; b.din3_valid = 0;

    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].do_reset) pulse_reset();
      @(posedge clk); #1;
      feed4(vecs[i].ch, vecs[i].s[0], vecs[i].s[1], vecs[i].s[2], vecs[i].s[3]);
      check($sformatf("v%0d_en", i), 32'(get_en(vecs[i].ch)), 32'h1);
      check($sformatf("v%0d_max", i), 32'(get_max(vecs[i].ch)), 32'(vecs[i].emax));
      check($sformatf("v%0d_min", i), 32'(get_min(vecs[i].ch)), 32'(vecs[i].emin));
      n = 1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (!get_en(vecs[i].ch)) break;
        n++;
      end
      check($sformatf("v%0d_hold_len", i), 32'(n), 32'd4);
      check($sformatf("v%0d_gap_max", i), 32'(get_max(vecs[i].ch)), 32'(vecs[i].emax));
      check($sformatf("v%0d_gap_min", i), 32'(get_min(vecs[i].ch)), 32'(vecs[i].emin));
      if (vecs[i].do_reset) begin
        for (int c = 0; c < 4; c++) begin
          if (c != vecs[i].ch) begin
            check($sformatf("v%0d_iso_en%0d", i, c), 32'(get_en(c)), 32'h0);
            check($sformatf("v%0d_iso_max%0d", i, c), 32'(get_max(c)), 32'h0);
            check($sformatf("v%0d_iso_min%0d", i, c), 32'(get_min(c)), 32'h0);
          end
        end
      end
      repeat (2) @(posedge clk);
      #1;
    end

    // Partial window on ch3 is discarded by a mid-cycle reset.
    set_in(3, 16'hF000, 1'b1);
    repeat (2) @(posedge clk);
    #1 set_in(3, 16'h0, 1'b0);
    #2 rst = 1'b1;
    #1 check("t6_rst_max", 32'(get_max(3)), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    feed4(3, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    check("t6_en", 32'(get_en(3)), 32'h1);
    check("t6_max", 32'(get_max(3)), 32'h0400);
    check("t6_min", 32'(get_min(3)), 32'h0100);
    repeat (6) @(posedge clk);
    #1;

    // WIN_LEN=2 back-to-back completions on ch1 of the second instance.
    rise_edge = '{1, 7, 13};
    r_max = '{16'd2, 16'd6, 16'd12};
    r_min = '{16'd1, 16'd5, 16'd11};
    rises = 0; run = 0; prev = 1'b0;
    b.din1_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b.din1 = 16'(k + 1);
      @(posedge clk); #1;
      en = b.dat1_max_en;
      if (en && !prev) begin
        if (rises < 3) begin
          check($sformatf("t4_rise%0d_edge", rises), 32'(k), 32'(rise_edge[rises]));
          check($sformatf("t4_rise%0d_max", rises), 32'(b.dat1_max), 32'(r_max[rises]));
          check($sformatf("t4_rise%0d_min", rises), 32'(b.dat1_min), 32'(r_min[rises]));
        end
        rises++;
      end
      if (!en && prev) check($sformatf("t4_high_len_k%0d", k), 32'(run), 32'd4);
      run = en ? run + 1 : 0;
      if (k == 4) check("t4_ovf_before", 32'(b.dat1_ovf), 32'h0);
      if (k == 5) check("t4_ovf_set", 32'(b.dat1_ovf), 32'h1);
      prev = en;
    end
    b.din1_valid = 1'b0;
    check("t4_rises", 32'(rises), 32'd3);
    check("t4_ovf_sticky", 32'(b.dat1_ovf), 32'h1);

    // Reset in the middle of a HOLD drops everything at once.
    @(posedge clk); #1;
    feed4(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    check("t1_pre_en", 32'(get_en(0)), 32'h1);
    #2 rst = 1'b1;
    #1 check_zero("t1_async");
    check("t1_b_ovf", 32'(b.dat1_ovf), 32'h0);
    check("t1_b_en", 32'(b.dat1_max_en), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
